shift_right_seq: RTL



---
 rtl/shift_right_seq_if.sv | 25 ++
 rtl/shift_right_seq.sv | 101 ++++++++++
 2 files changed

// File: rtl/shift_right_seq_if.sv
// Request/response bundle between the control unit and the multi-cycle
// right shifter. The master issues shift requests and observes
// busy/done/result.
interface shift_right_seq_if #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 5
);
  logic                   start;
  logic                   arith;
  logic [WIDTH-1:0]       in_data;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   busy;
  logic                   done;
  logic [WIDTH-1:0]       out_data;

  modport master (
    output start, arith, in_data, shamt,
    input  busy, done, out_data
  );

  modport slave (
    input  start, arith, in_data, shamt,
    output busy, done, out_data
  );
endinterface

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (SRL/SRLV/SRA/SRAV) for the execute stage.
// The shifter moves the operand one bit position per clock. The fill bit is
// latched when the operand is captured, so arithmetic shifts replicate the
// original sign bit. Shift amounts of WIDTH or more therefore yield all-fill
// without any extra logic. All outputs come straight from flops.
module shift_right_seq #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  shift_right_seq_if.slave         bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [WIDTH-1:0]       wr_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic                   fb_q;
  logic                   busy_q;
  logic                   done_q;
  logic [WIDTH-1:0]       out_q;

  logic [WIDTH-1:0]       wr_d;
  logic [SHAMT_WIDTH-1:0] cnt_d;
  logic                   last_d;

  // Next working value and count for one shift step.
  always_comb begin
    wr_d   = {fb_q, wr_q[WIDTH-1:1]};
    cnt_d  = cnt_q - SHAMT_WIDTH'(1);
    last_d = (cnt_q == SHAMT_WIDTH'(1));
  end

  // Control FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      wr_q    <= '0;
      cnt_q   <= '0;
      fb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            wr_q  <= bus.in_data;
            cnt_q <= bus.shamt;
            fb_q  <= bus.arith & bus.in_data[WIDTH-1];
            if (bus.shamt != SHAMT_WIDTH'(0)) begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              // Zero-length shift completes immediately with the operand.
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              out_q   <= bus.in_data;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          wr_q  <= wr_d;
          cnt_q <= cnt_d;
          if (last_d) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= wr_d;
          end else begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.out_data = out_q;

endmodule
